uart_baud_gen: RTL and testbench

Parametrised baud-rate generator shared by the UART receiver and transmitter. It derives an oversampling strobe, a mid-bit strobe and a bit strobe from a single system clock for eight runtime-selectable baud rates. An optional fractional divider cuts rate error at high baud rates. The receiver can re-phase the timebase on a start-bit edge.

---
 rtl/uart_baud_gen.sv | 123 ++++++++++++
 tb/tb_uart_baud_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// Baud-rate timebase: oversampling, mid-bit and bit-end strobes for eight selectable rates.
// Define UART_BAUD_FRACTIONAL_EN to compile in the DI/DI+1 fractional divider.
module uart_baud_gen #(
  parameter int unsigned CLK_HZ     = 150_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FRAC_W     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [2:0] i_baud_select,
  input  logic       i_rx_resync,
  output logic       o_sample_tick,
  output logic       o_mid_tick,
  output logic       o_bit_tick
);
  localparam int unsigned      OS_W   = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_MID = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0]  OS_END = OS_W'(OVERSAMPLE - 1);

  function automatic longint unsigned rate_div(input int unsigned sel);
    longint unsigned b;
    case (sel)
      0:       b = 300;
      1:       b = 1200;
      2:       b = 4800;
      3:       b = 9600;
      4:       b = 19200;
      5:       b = 38400;
      6:       b = 57600;
      default: b = 115200;
    endcase
    return b * 64'(OVERSAMPLE);
  endfunction

  logic [CNT_W-1:0] w_last_tbl [8];
`ifdef UART_BAUD_FRACTIONAL_EN
  logic [FRAC_W-1:0] w_df_tbl [8];
`endif

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rate
      localparam longint unsigned D = rate_div(gi);
`ifdef UART_BAUD_FRACTIONAL_EN
      localparam longint unsigned DI_RAW = CLK_HZ / D;
      localparam longint unsigned DF_RAW = (((CLK_HZ % D) << FRAC_W) + D/2) / D;
      localparam bit              DF_OVF = (DF_RAW == (64'd1 << FRAC_W));
      localparam longint unsigned DI     = DF_OVF ? DI_RAW + 1 : DI_RAW;
      localparam longint unsigned DF     = DF_OVF ? 64'd0 : DF_RAW;
      // Terminal count for a short period; long_q stretches it by one.
      assign w_last_tbl[gi] = CNT_W'(DI - 1);
      assign w_df_tbl[gi]   = FRAC_W'(DF);
`else
      localparam longint unsigned P = (CLK_HZ + D/2) / D;
      assign w_last_tbl[gi] = CNT_W'(P - 1);
`endif
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic [OS_W-1:0]  r_os_cnt;
  logic [2:0]       r_sel_q;
  logic             w_sel_chg;
  logic             w_clear;
  logic             w_hit;
  logic [CNT_W-1:0] w_last;

  // A rate change only counts while enabled; a disabled generator holds its old selection.
  assign w_sel_chg = i_enable && (i_baud_select != r_sel_q);
  assign w_clear   = !i_enable || w_sel_chg || i_rx_resync;

`ifdef UART_BAUD_FRACTIONAL_EN
  logic [FRAC_W-1:0] r_acc;
  logic              r_long_q;
  logic [FRAC_W:0]   w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_df_tbl[r_sel_q]};
  assign w_last    = w_last_tbl[r_sel_q] + CNT_W'(r_long_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_long_q <= 1'b0;
    end else if (w_clear) begin
      r_acc    <= '0;
      r_long_q <= 1'b0;
    end else if (w_hit) begin
      r_acc    <= w_acc_sum[FRAC_W-1:0];
      r_long_q <= w_acc_sum[FRAC_W];
    end
  end
`else
  assign w_last = w_last_tbl[r_sel_q];
`endif

  assign w_hit = !w_clear && (r_cnt == w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_os_cnt      <= '0;
      r_sel_q       <= i_baud_select;
      o_sample_tick <= 1'b0;
      o_mid_tick    <= 1'b0;
      o_bit_tick    <= 1'b0;
    end else begin
      o_sample_tick <= w_hit;
      o_mid_tick    <= w_hit && (r_os_cnt == OS_MID);
      o_bit_tick    <= w_hit && (r_os_cnt == OS_END);
      if (w_sel_chg)
        r_sel_q <= i_baud_select;
      if (w_clear || w_hit)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_clear)
        r_os_cnt <= '0;
      else if (w_hit)
        r_os_cnt <= (r_os_cnt == OS_END) ? '0 : r_os_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboarded bench for uart_baud_gen: random and directed stimulus against an arithmetic tick-time model.
module tb_uart_baud_gen;
  localparam int unsigned CLK_HZ = 150_000_000;
  localparam int unsigned OS     = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FRAC_W = 8;

`ifdef UART_BAUD_FRACTIONAL_EN
  localparam longint P9600_FIRST  = 976;
  localparam longint MID115_FIRST = 650;
  localparam longint P57600_FIRST = 162;
`else
  localparam longint P9600_FIRST  = 977;
  localparam longint MID115_FIRST = 648;
  localparam longint P57600_FIRST = 163;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rx_resync = 1'b0;
  logic [2:0] baud_select = 3'd0;
  logic       sample_tick, mid_tick, bit_tick;

  uart_baud_gen #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(OS), .CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_baud_select(baud_select),
    .i_rx_resync(rx_resync), .o_sample_tick(sample_tick), .o_mid_tick(mid_tick),
    .o_bit_tick(bit_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint     e;
    logic [2:0] v;
  } exp_t;

  exp_t   exp_q[$];
  longint s_q[$], m_q[$], b_q[$];
  int     checks = 0;
  int     errors = 0;
  longint di_tbl[8], df_tbl[8];
  int     baud_tbl[8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
  longint m_phase = 0, m_n = 0, edge_idx = 0, m_clear_edge = 0;
  logic [2:0] m_sel = 3'd0;
  logic [2:0] last_exp = 3'd0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Edge (counted from the last clear) on which the n-th sample tick appears.
  function automatic longint tick_at(input longint n, input logic [2:0] s);
    return n * di_tbl[s] + ((n - 1) * df_tbl[s]) / (longint'(1) << FRAC_W);
  endfunction

  function automatic longint first_after(input int k, input longint e);
    longint v;
    v = -1;
    case (k)
      0: foreach (s_q[i]) if (v < 0 && s_q[i] > e) v = s_q[i];
      1: foreach (m_q[i]) if (v < 0 && m_q[i] > e) v = m_q[i];
      default: foreach (b_q[i]) if (v < 0 && b_q[i] > e) v = b_q[i];
    endcase
    return v;
  endfunction

  task automatic model_clear();
    m_phase      = 0;
    m_n          = 0;
    m_clear_edge = edge_idx;
  endtask

  task automatic step(input logic r, input logic en, input logic [2:0] sel, input logic rs);
    exp_t x;
    @(negedge clk);
    rst_n = r; enable = en; baud_select = sel; rx_resync = rs;
    x.e = edge_idx;
    x.v = 3'b000;
    if (!r) begin
      m_sel = sel;
      model_clear();
    end else if (!en) begin
      model_clear();
    end else if (sel != m_sel) begin
      m_sel = sel;
      model_clear();
    end else if (rs) begin
      model_clear();
    end else begin
      m_phase++;
      if (m_phase == tick_at(m_n + 1, m_sel)) begin
        m_n++;
        x.v = {1'b1, (m_n % OS) == OS/2, (m_n % OS) == 0};
      end
    end
    exp_q.push_back(x);
    last_exp = x.v;
    edge_idx++;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    s_q.delete(); m_q.delete(); b_q.delete();
  endtask

  initial begin : monitor
    exp_t mx;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mx = exp_q.pop_front();
        checks++;
        if ({sample_tick, mid_tick, bit_tick} !== mx.v) begin
          errors++;
          if (errors <= 20)
            $display("FAIL ticks edge=%0d got=%b want=%b", mx.e,
                     {sample_tick, mid_tick, bit_tick}, mx.v);
        end
        if (sample_tick) s_q.push_back(mx.e);
        if (mid_tick)    m_q.push_back(mx.e);
        if (bit_tick)    b_q.push_back(mx.e);
      end
    end
  end

  initial begin : driver
    longint clr, pmax, d;
    int     bad, k;
    logic [2:0] rsel;
    logic   rr, ren, rrs;

    for (int s = 0; s < 8; s++) begin
      real n;
      n = real'(CLK_HZ) / (real'(baud_tbl[s]) * real'(OS));
`ifdef UART_BAUD_FRACTIONAL_EN
      di_tbl[s] = longint'($floor(n));
      df_tbl[s] = longint'($floor((n - real'(di_tbl[s])) * real'(longint'(1) << FRAC_W) + 0.5));
      if (df_tbl[s] == (longint'(1) << FRAC_W)) begin
        di_tbl[s] = di_tbl[s] + 1;
        df_tbl[s] = 0;
      end
`else
      di_tbl[s] = longint'($floor(n + 0.5));
      df_tbl[s] = 0;
`endif
      pmax = di_tbl[s] + ((df_tbl[s] != 0) ? 1 : 0);
      if (pmax >= (longint'(1) << CNT_W)) begin
        $display("FAIL elab_period sel=%0d: period %0d does not fit CNT_W=%0d", s, pmax, CNT_W);
        $fatal(1, "illegal configuration");
      end
    end

    // Reset release straight into 115200 baud.
    repeat (3) step(1'b0, 1'b1, 3'd7, 1'b0);
    clr = m_clear_edge;
`ifdef UART_BAUD_FRACTIONAL_EN
    repeat (21200) step(1'b1, 1'b1, 3'd7, 1'b0);
`else
    repeat (2700) step(1'b1, 1'b1, 3'd7, 1'b0);
`endif
    settle();
    check("s1_first_sample", first_after(0, clr) - clr, 81);
    check("s1_first_mid", first_after(1, clr) - clr, MID115_FIRST);
    bad = 0;
    for (int i = 1; i < s_q.size(); i++) begin
      d = s_q[i] - s_q[i-1];
`ifdef UART_BAUD_FRACTIONAL_EN
      if (d != 81 && d != 82) bad++;
`else
      if (d != 81) bad++;
`endif
    end
    check("s1_bad_periods", bad, 0);
`ifdef UART_BAUD_FRACTIONAL_EN
    if (s_q.size() < 257) begin
      check("s2_tick_count", s_q.size(), 257);
    end else begin
      check("s2_span256_first", s_q[256] - s_q[0], 20833);
      k = $urandom_range(0, s_q.size() - 257);
      check("s2_span256_rand", s_q[k+256] - s_q[k], 20833);
    end
`else
    check("s1_first_bit", first_after(2, clr) - clr, 1296);
    check("s1_bit_period", (b_q.size() >= 2) ? b_q[1] - b_q[0] : -1, 1296);
`endif
    $display("scenario reset_115200 done at edge %0d", edge_idx);

    // 300 baud, then switch to 9600 mid-period.
    clear_logs();
    step(1'b1, 1'b1, 3'd0, 1'b0);
    clr = m_clear_edge;
    repeat (31299) step(1'b1, 1'b1, 3'd0, 1'b0);
    settle();
    check("s3_p300", first_after(0, clr) - clr, 31250);
    step(1'b1, 1'b1, 3'd3, 1'b0);
    clr = m_clear_edge;
    repeat (1000) step(1'b1, 1'b1, 3'd3, 1'b0);
    settle();
    check("s3_p9600_first", first_after(0, clr) - clr, P9600_FIRST);
    $display("scenario rate_switch done at edge %0d", edge_idx);

    // Resync at a random phase, then resync coincident with a baud change.
    clear_logs();
    repeat (200 + $urandom_range(0, 100)) step(1'b1, 1'b1, 3'd7, 1'b0);
    step(1'b1, 1'b1, 3'd7, 1'b1);
    clr = m_clear_edge;
    repeat (700) step(1'b1, 1'b1, 3'd7, 1'b0);
    settle();
    check("s4_resync_sample", first_after(0, clr) - clr, 81);
    check("s4_resync_mid", first_after(1, clr) - clr, MID115_FIRST);
    step(1'b1, 1'b1, 3'd5, 1'b1);
    clr = m_clear_edge;
    repeat (300) step(1'b1, 1'b1, 3'd5, 1'b0);
    settle();
    check("s4_resync_and_change", first_after(0, clr) - clr, 244);
    $display("scenario resync done at edge %0d", edge_idx);

    // Enable low for 100 cycles mid-bit.
    repeat (500) step(1'b1, 1'b1, 3'd7, 1'b0);
    clr = edge_idx;
    repeat (100) step(1'b1, 1'b0, 3'd7, 1'b0);
    pmax = m_clear_edge;
    repeat (200) step(1'b1, 1'b1, 3'd7, 1'b0);
    settle();
    check("s5_quiet_while_disabled", first_after(0, clr - 1) - pmax, 81);
    $display("scenario enable_gap done at edge %0d", edge_idx);

    // Asynchronous reset on a tick, with the rate selection changed during reset.
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'b1, 3'd7, 1'b0);
      if (last_exp[2]) break;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_clear", {sample_tick, mid_tick, bit_tick}, 0);
    repeat (3) step(1'b0, 1'b1, 3'd6, 1'b0);
    clr = m_clear_edge;
    repeat (400) step(1'b1, 1'b1, 3'd6, 1'b0);
    settle();
    check("s6_no_spurious_clear", first_after(0, clr) - clr, P57600_FIRST);
    $display("scenario async_reset done at edge %0d", edge_idx);

    // Random traffic at the faster rates.
    rsel = 3'd7;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 399) == 0) rsel = 3'($urandom_range(4, 7));
      rr  = ($urandom_range(0, 4999) != 0);
      ren = ($urandom_range(0, 299) != 0);
      rrs = ($urandom_range(0, 149) == 0);
      step(rr, ren, rsel, rrs);
    end
    repeat (3) settle();
    $display("scenario random done at edge %0d", edge_idx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
